// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared CDB types and helpers. The scheduler and the ROB reuse
//               the same tag and slot types.
//               phy_tag_t  : physical register tag
//               cdb_slot_t : one broadcast slot {valid, tag, unit}
//               rr_next()  : modulo increment used by round-robin pointers
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

  localparam int CDB_PHY_TAG_W = 6;
  localparam int CDB_UNIT_W    = 2;

  typedef logic [CDB_PHY_TAG_W-1:0] phy_tag_t;

  typedef struct packed {
    logic                  valid;
    phy_tag_t              tag;
    logic [CDB_UNIT_W-1:0] unit;
  } cdb_slot_t;

  // Next position after idx, wrapping modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : cdb_rr_picker
// Description : Combinational find-first-set starting at a pointer, wrapping
//               modulo N.
// Ports       : req_i   [N]    candidate request vector
//               start_i [IdxW] first position scanned
//               found_o        any request set
//               idx_o   [IdxW] first set position in scan order
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic            found_o,
  output logic [IdxW-1:0] idx_o
);

  // Scan in reverse so the final assignment wins: that is the earliest
  // position in scan order, without needing a loop break.
  always_comb begin : p_pick
    int j;
    j       = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(start_i) + i) % N;
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IdxW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin arbiter sharing CDBWidth common-data-bus slots
//               between NumUnits writeback requesters, followed by a single
//               registered broadcast stage.
// Ports       : clk_i        clock
//               rst_ni       asynchronous active-low reset
//               flush_i      pipeline flush (blocks grants, kills broadcast)
//               req_valid_i  [NumUnits] unit has a result
//               req_tag_i    [NumUnits] destination tag per unit
//               req_ready_o  [NumUnits] grant
//               cdb_valid_o  [CDBWidth] broadcast slot valid
//               cdb_tag_o    [CDBWidth] broadcast tag per slot
//               cdb_unit_o   [CDBWidth] winning unit per slot
// Options     : CDB_ARB_FAST_PRIORITY_EN - fast units first, with starvation
//               promotion of slow units.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int                  NumUnits      = 4,
  parameter int                  CDBWidth      = 1,
  parameter int                  PhyRegIDWidth = CDB_PHY_TAG_W,
  parameter logic [NumUnits-1:0] FastUnitMask  = NumUnits'(1),
  parameter int                  StarveLimit   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [NumUnits-1:0]          req_valid_i,
  input  logic [PhyRegIDWidth-1:0]     req_tag_i   [NumUnits],
  output logic [NumUnits-1:0]          req_ready_o,
  output logic [CDBWidth-1:0]          cdb_valid_o,
  output logic [PhyRegIDWidth-1:0]     cdb_tag_o   [CDBWidth],
  output logic [$clog2(NumUnits)-1:0]  cdb_unit_o  [CDBWidth]
);

  localparam int UnitW = $clog2(NumUnits);

  logic [UnitW-1:0]         r_rr_ptr;
  logic [CDBWidth-1:0]      r_cdb_valid;
  logic [PhyRegIDWidth-1:0] r_cdb_tag  [CDBWidth];
  logic [UnitW-1:0]         r_cdb_unit [CDBWidth];

  logic                     w_block;
  logic [NumUnits-1:0]      w_grant;
  logic                     w_slot_hit  [CDBWidth];
  logic [UnitW-1:0]         w_slot_unit [CDBWidth];
  logic                     w_any;
  logic [UnitW-1:0]         w_last;

  // No grant while flushing or while reset is held.
  assign w_block = flush_i | ~rst_ni;

`ifdef CDB_ARB_FAST_PRIORITY_EN
  localparam int CntW = $clog2(StarveLimit + 1);

  logic [CntW-1:0]     r_starve [NumUnits];
  logic [NumUnits-1:0] w_starved;

  // Only slow units can starve; fast units always sit in the first pass.
  always_comb begin
    w_starved = '0;
    for (int u = 0; u < NumUnits; u++) begin
      w_starved[u] = ~FastUnitMask[u] && (r_starve[u] == CntW'(StarveLimit));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int u = 0; u < NumUnits; u++) r_starve[u] <= '0;
    end else begin
      for (int u = 0; u < NumUnits; u++) begin
        if (flush_i || FastUnitMask[u] || req_ready_o[u]) begin
          r_starve[u] <= '0;
        end else if (req_valid_i[u] && (r_starve[u] != CntW'(StarveLimit))) begin
          r_starve[u] <= r_starve[u] + CntW'(1);
        end
      end
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{FastUnitMask, StarveLimit[0]};
`endif

  // Slot k picks from whatever earlier slots left over, so slot k holds the
  // k-th winner in scan order.
  for (genvar k = 0; k < CDBWidth; k++) begin : g_slot
    logic [NumUnits-1:0] w_taken_in;
    logic [NumUnits-1:0] w_taken_out;
    logic [NumUnits-1:0] w_avail;
    logic                w_hit;
    logic [UnitW-1:0]    w_unit;

    if (k == 0) begin : g_first
      assign w_taken_in = '0;
    end else begin : g_next
      assign w_taken_in = g_slot[k-1].w_taken_out;
    end

    assign w_avail = req_valid_i & ~w_taken_in;

`ifdef CDB_ARB_FAST_PRIORITY_EN
    logic             w_hit_st, w_hit_fa, w_hit_sl;
    logic [UnitW-1:0] w_idx_st, w_idx_fa, w_idx_sl;

    // Starved slow units: fixed priority, lowest index first.
    cdb_rr_picker #(.N(NumUnits), .IdxW(UnitW)) u_pick_starve (
      .req_i   (w_avail & w_starved),
      .start_i ('0),
      .found_o (w_hit_st),
      .idx_o   (w_idx_st)
    );

    cdb_rr_picker #(.N(NumUnits), .IdxW(UnitW)) u_pick_fast (
      .req_i   (w_avail & FastUnitMask),
      .start_i (r_rr_ptr),
      .found_o (w_hit_fa),
      .idx_o   (w_idx_fa)
    );

    cdb_rr_picker #(.N(NumUnits), .IdxW(UnitW)) u_pick_slow (
      .req_i   (w_avail & ~FastUnitMask),
      .start_i (r_rr_ptr),
      .found_o (w_hit_sl),
      .idx_o   (w_idx_sl)
    );

    assign w_hit  = w_hit_st | w_hit_fa | w_hit_sl;
    assign w_unit = w_hit_st ? w_idx_st : (w_hit_fa ? w_idx_fa : w_idx_sl);
`else
    cdb_rr_picker #(.N(NumUnits), .IdxW(UnitW)) u_pick (
      .req_i   (w_avail),
      .start_i (r_rr_ptr),
      .found_o (w_hit),
      .idx_o   (w_unit)
    );
`endif

    assign w_taken_out    = w_taken_in | (w_hit ? (NumUnits'(1) << w_unit) : '0);
    assign w_slot_hit[k]  = w_hit;
    assign w_slot_unit[k] = w_unit;
  end

  assign w_grant     = g_slot[CDBWidth-1].w_taken_out;
  assign req_ready_o = w_block ? '0 : w_grant;

  // Slots fill in order, so the last hit slot carries the last winner.
  always_comb begin
    w_any  = 1'b0;
    w_last = '0;
    for (int k = 0; k < CDBWidth; k++) begin
      if (w_slot_hit[k]) begin
        w_any  = 1'b1;
        w_last = w_slot_unit[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= '0;
      for (int k = 0; k < CDBWidth; k++) begin
        r_cdb_tag[k]  <= '0;
        r_cdb_unit[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CDBWidth; k++) begin
        if (!flush_i && w_slot_hit[k]) begin
          r_cdb_valid[k] <= 1'b1;
          r_cdb_tag[k]   <= req_tag_i[w_slot_unit[k]];
          r_cdb_unit[k]  <= w_slot_unit[k];
        end else begin
          r_cdb_valid[k] <= 1'b0;
          r_cdb_tag[k]   <= '0;
          r_cdb_unit[k]  <= '0;
        end
      end
      if (!flush_i && w_any) begin
        r_rr_ptr <= UnitW'(rr_next(int'(w_last), NumUnits));
      end
    end
  end

  assign cdb_valid_o = r_cdb_valid;
  assign cdb_tag_o   = r_cdb_tag;
  assign cdb_unit_o  = r_cdb_unit;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter. Three instances:
//               u_dut1 (CDBWidth=1, no fast units), u_dut2 (CDBWidth=2),
//               u_dut3 (CDBWidth=1, unit 0 fast, StarveLimit=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  logic       clk;
  logic       rst_n;

  logic       f1, f2, f3;
  logic [3:0] v1, v2, v3;
  logic [5:0] t1 [4];
  logic [5:0] t2 [4];
  logic [5:0] t3 [4];
  logic [3:0] r1, r2, r3;
  logic [0:0] cv1, cv3;
  logic [1:0] cv2;
  logic [5:0] ct1 [1];
  logic [5:0] ct2 [2];
  logic [5:0] ct3 [1];
  logic [1:0] cu1 [1];
  logic [1:0] cu2 [2];
  logic [1:0] cu3 [1];

  int n_vec  = 0;
  int n_miss = 0;

  cdb_arbiter #(.NumUnits(4), .CDBWidth(1), .PhyRegIDWidth(6),
                .FastUnitMask(4'b0000), .StarveLimit(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f1), .req_valid_i(v1), .req_tag_i(t1),
    .req_ready_o(r1), .cdb_valid_o(cv1), .cdb_tag_o(ct1), .cdb_unit_o(cu1)
  );

  cdb_arbiter #(.NumUnits(4), .CDBWidth(2), .PhyRegIDWidth(6),
                .FastUnitMask(4'b0000), .StarveLimit(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f2), .req_valid_i(v2), .req_tag_i(t2),
    .req_ready_o(r2), .cdb_valid_o(cv2), .cdb_tag_o(ct2), .cdb_unit_o(cu2)
  );

  cdb_arbiter #(.NumUnits(4), .CDBWidth(1), .PhyRegIDWidth(6),
                .FastUnitMask(4'b0001), .StarveLimit(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f3), .req_valid_i(v3), .req_tag_i(t3),
    .req_ready_o(r3), .cdb_valid_o(cv3), .cdb_tag_o(ct3), .cdb_unit_o(cu3)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp3 [10];

  initial begin
`ifdef CDB_ARB_FAST_PRIORITY_EN
    exp3 = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
`else
    exp3 = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 2};
`endif
    clk   = 1'b0;
    rst_n = 1'b0;
    f1 = 1'b0; f2 = 1'b0; f3 = 1'b0;
    v2 = 4'b0000; v3 = 4'b0000;
    for (int u = 0; u < 4; u++) begin
      t1[u] = 6'(10 + u);
      t2[u] = 6'(20 + u);
      t3[u] = 6'(30 + u);
    end

    // Reset held with all units requesting
    v1 = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_ready", 32'(r1), 32'h0);
    check_vec("rst_cdb_valid1", 32'(cv1), 32'h0);
    check_vec("rst_cdb_valid2", 32'(cv2), 32'h0);
    check_vec("rst_cdb_tag1", 32'(ct1[0]), 32'h0);
    #2 rst_n = 1'b1;
    #1;

    // Round-robin order with all units valid; first grant is unit 0
    for (int i = 0; i < 8; i++) begin
      check_vec("rr_ready", 32'(r1), 32'(1 << (i % 4)));
      tick();
      check_vec("rr_cdb_valid", 32'(cv1), 32'h1);
      check_vec("rr_cdb_unit", 32'(cu1[0]), 32'(i % 4));
      check_vec("rr_cdb_tag", 32'(ct1[0]), 32'(10 + i % 4));
      #1;
    end

    // Flush: unit 2 granted in N, flush in N+1 with unit 3 waiting
    v1 = 4'b0100;
    #1;
    check_vec("fl_grant2", 32'(r1), 32'h4);
    tick();
    v1 = 4'b1000;
    f1 = 1'b1;
    #1;
    check_vec("fl_n1_valid", 32'(cv1), 32'h1);
    check_vec("fl_n1_tag", 32'(ct1[0]), 32'd12);
    check_vec("fl_n1_ready", 32'(r1), 32'h0);
    tick();
    f1 = 1'b0;
    #1;
    check_vec("fl_n2_valid", 32'(cv1), 32'h0);
    check_vec("fl_n2_ready", 32'(r1), 32'h8);
    tick();
    v1 = 4'b0000;
    check_vec("fl_n3_valid", 32'(cv1), 32'h1);
    check_vec("fl_n3_unit", 32'(cu1[0]), 32'h3);

    // Asynchronous reset between edges while broadcasting
    #3 rst_n = 1'b0;
    #1;
    check_vec("arst_valid", 32'(cv1), 32'h0);
    check_vec("arst_tag", 32'(ct1[0]), 32'h0);
    check_vec("arst_unit", 32'(cu1[0]), 32'h0);
    #2 rst_n = 1'b1;
    tick();

    // CDBWidth=2: move pointer to 2, then units 1 and 3 compete
    v2 = 4'b0010;
    #1;
    check_vec("w2_ready_a", 32'(r2), 32'h2);
    tick();
    check_vec("w2_valid_a", 32'(cv2), 32'h1);
    check_vec("w2_tag_a0", 32'(ct2[0]), 32'd21);
    v2 = 4'b1010;
    #1;
    check_vec("w2_ready_b", 32'(r2), 32'ha);
    tick();
    check_vec("w2_valid_b", 32'(cv2), 32'h3);
    check_vec("w2_tag_b0", 32'(ct2[0]), 32'd23);
    check_vec("w2_tag_b1", 32'(ct2[1]), 32'd21);
    check_vec("w2_unit_b0", 32'(cu2[0]), 32'h3);
    check_vec("w2_unit_b1", 32'(cu2[1]), 32'h1);
    v2 = 4'b1110;
    #1;
    check_vec("w2_ready_c", 32'(r2), 32'hc);
    tick();
    check_vec("w2_unit_c0", 32'(cu2[0]), 32'h2);
    check_vec("w2_unit_c1", 32'(cu2[1]), 32'h3);
    v2 = 4'b0000;

    // Fast unit 0 and slow unit 2 requesting continuously
    v3 = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_vec("fast_ready", 32'(r3), 32'(1 << exp3[i]));
      tick();
      check_vec("fast_unit", 32'(cu3[0]), 32'(exp3[i]));
      check_vec("fast_tag", 32'(ct3[0]), 32'(30 + exp3[i]));
    end
    v3 = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
